// File: rtl/pcpi_bf16_add_ctrl.sv
// PCPI-side controller for an external bf16 adder.
// Decodes the custom-0 bf16 add/sub instructions, feeds operands to the adder
// over its STB/BUSY input handshake, collects results over its STB/BUSY output
// handshake and returns rd to the core. Packed (2-lane) ops run both lanes
// through the single adder, low lane first.
module pcpi_bf16_add_ctrl #(
    parameter logic [6:0] OPCODE = 7'b0001011,
    parameter logic [6:0] FUNCT7 = 7'b0100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready,
    output logic [15:0] adder_input_a,
    output logic [15:0] adder_input_b,
    output logic        adder_input_STB,
    input  logic        adder_BUSY,
    input  logic [15:0] adder_sum,
    input  logic        adder_output_STB,
    output logic        output_module_BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] rs1_reg, rs1_next;
    logic [31:0] rs2_reg, rs2_next;
    logic        sub_reg, sub_next;
    logic        packed_reg, packed_next;
    logic        lane_reg, lane_next;
    logic [15:0] lane0_sum_reg, lane0_sum_next;
    logic        abort_reg, abort_next;
    logic        wr_reg, wr_next;
    logic        ready_reg, ready_next;
    logic        wait_reg, wait_next;
    logic [31:0] rd_reg, rd_next;
    logic [15:0] a_reg, a_next;
    logic [15:0] b_reg, b_next;
    logic        stb_reg, stb_next;
    logic        om_busy_reg, om_busy_next;

    logic        match;
    logic        in_xfer;
    logic        out_xfer;

    // funct3[2] must be clear; funct3[0] selects SUB, funct3[1] selects packed.
    assign match = pcpi_valid
                && (pcpi_insn[6:0] == OPCODE)
                && (pcpi_insn[31:25] == FUNCT7)
                && (pcpi_insn[14] == 1'b0);

    assign in_xfer  = stb_reg && !adder_BUSY;
    assign out_xfer = adder_output_STB && !om_busy_reg;

    // Next-state and registered-output logic; every register holds by default.
    always_comb begin
        state_next     = state_reg;
        rs1_next       = rs1_reg;
        rs2_next       = rs2_reg;
        sub_next       = sub_reg;
        packed_next    = packed_reg;
        lane_next      = lane_reg;
        lane0_sum_next = lane0_sum_reg;
        abort_next     = abort_reg;
        wr_next        = wr_reg;
        ready_next     = ready_reg;
        wait_next      = wait_reg;
        rd_next        = rd_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        stb_next       = stb_reg;
        om_busy_next   = om_busy_reg;

        case (state_reg)
            IDLE: begin
                if (match) begin
                    rs1_next    = pcpi_rs1;
                    rs2_next    = pcpi_rs2;
                    sub_next    = pcpi_insn[12];
                    packed_next = pcpi_insn[13];
                    lane_next   = 1'b0;
                    abort_next  = 1'b0;
                    wait_next   = 1'b1;
                    // Lane 0 operands go out with STB on entry to ISSUE.
                    a_next      = pcpi_rs1[15:0];
                    b_next      = pcpi_rs2[15:0] ^ {pcpi_insn[12], 15'h0000};
                    stb_next    = 1'b1;
                    state_next  = ISSUE;
                end
            end

            ISSUE: begin
                if (in_xfer) begin
                    // A transfer always wins so the adder's result gets drained.
                    stb_next     = 1'b0;
                    om_busy_next = 1'b0;
                    abort_next   = !pcpi_valid;
                    state_next   = WAIT;
                end else if (!pcpi_valid) begin
                    stb_next   = 1'b0;
                    wait_next  = 1'b0;
                    state_next = IDLE;
                end
            end

            WAIT: begin
                abort_next = abort_reg || !pcpi_valid;
                if (out_xfer) begin
                    om_busy_next = 1'b1;
                    if (!lane_reg) begin
                        lane0_sum_next = adder_sum;
                    end
                    if (abort_next) begin
                        wait_next  = 1'b0;
                        state_next = IDLE;
                    end else if (packed_reg && !lane_reg) begin
                        lane_next  = 1'b1;
                        a_next     = rs1_reg[31:16];
                        b_next     = rs2_reg[31:16] ^ {sub_reg, 15'h0000};
                        stb_next   = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        ready_next = 1'b1;
                        wr_next    = 1'b1;
                        wait_next  = 1'b0;
                        rd_next    = packed_reg ? {adder_sum, lane0_sum_reg}
                                                : {16'h0000, adder_sum};
                        state_next = DONE;
                    end
                end
            end

            DONE: begin
                ready_next = 1'b0;
                wr_next    = 1'b0;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            rs1_reg       <= '0;
            rs2_reg       <= '0;
            sub_reg       <= 1'b0;
            packed_reg    <= 1'b0;
            lane_reg      <= 1'b0;
            lane0_sum_reg <= '0;
            abort_reg     <= 1'b0;
            wr_reg        <= 1'b0;
            ready_reg     <= 1'b0;
            wait_reg      <= 1'b0;
            rd_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            stb_reg       <= 1'b0;
            om_busy_reg   <= 1'b1;
        end else begin
            state_reg     <= state_next;
            rs1_reg       <= rs1_next;
            rs2_reg       <= rs2_next;
            sub_reg       <= sub_next;
            packed_reg    <= packed_next;
            lane_reg      <= lane_next;
            lane0_sum_reg <= lane0_sum_next;
            abort_reg     <= abort_next;
            wr_reg        <= wr_next;
            ready_reg     <= ready_next;
            wait_reg      <= wait_next;
            rd_reg        <= rd_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            stb_reg       <= stb_next;
            om_busy_reg   <= om_busy_next;
        end
    end

    assign pcpi_wr            = wr_reg;
    assign pcpi_ready         = ready_reg;
    assign pcpi_wait          = wait_reg;
    assign pcpi_rd            = rd_reg;
    assign adder_input_a      = a_reg;
    assign adder_input_b      = b_reg;
    assign adder_input_STB    = stb_reg;
    assign output_module_BUSY = om_busy_reg;

endmodule

// File: tb/tb_pcpi_bf16_add_ctrl.sv
// Bench for pcpi_bf16_add_ctrl: plays the core and a behavioural bf16 adder,
// with a queue-based scoreboard checked by an independent monitor process.
module tb_pcpi_bf16_add_ctrl;

    localparam logic [6:0] OPC = 7'b0001011;
    localparam logic [6:0] F7  = 7'b0100000;

    logic        clk;
    logic        rst;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;
    logic [15:0] adder_input_a;
    logic [15:0] adder_input_b;
    logic        adder_input_STB;
    logic        adder_BUSY;
    logic [15:0] adder_sum;
    logic        adder_output_STB;
    logic        output_module_BUSY;

    pcpi_bf16_add_ctrl dut (
        .clk(clk), .rst(rst),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
        .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
        .adder_input_a(adder_input_a), .adder_input_b(adder_input_b),
        .adder_input_STB(adder_input_STB), .adder_BUSY(adder_BUSY),
        .adder_sum(adder_sum), .adder_output_STB(adder_output_STB),
        .output_module_BUSY(output_module_BUSY)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad = 0;
    int xfer_count = 0;
    int ready_count = 0;

    logic [31:0] exp_xfer_q[$];   // {a, b} the adder should receive, in order
    logic [31:0] exp_rd_q[$];     // rd expected at each pcpi_ready

    // Adder emulator controls
    bit force_busy = 0;
    bit rand_busy = 0;
    bit hold;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- bf16 reference arithmetic (via IEEE double) ----------------
    function automatic real bf2r(input logic [15:0] h);
        logic [10:0] e;
        if (h[14:7] == 8'd0) return 0.0;
        e = {3'b000, h[14:7]} + 11'd896;
        return $bitstoreal({h[15], e, h[6:0], 45'd0});
    endfunction

    function automatic logic [15:0] r2bf(input real r);
        logic [63:0] bits;
        logic [10:0] e;
        logic [44:0] rest;
        logic [44:0] half;
        logic [15:0] v;
        bits = $realtobits(r);
        if (bits[62:0] == 63'd0) return {bits[63], 15'h0000};
        e    = bits[62:52] - 11'd896;
        rest = bits[44:0];
        half = 45'd1 << 44;
        v    = {bits[63], e[7:0], bits[51:45]};
        if (rest > half || (rest == half && v[0])) v = v + 16'd1;
        return v;
    endfunction

    function automatic logic [15:0] bf16_add(input logic [15:0] a, input logic [15:0] b);
        return r2bf(bf2r(a) + bf2r(b));
    endfunction

    function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, OPC};
    endfunction

    function automatic logic [15:0] lane_of(input logic [31:0] w, input int l);
        return (l == 0) ? w[15:0] : w[31:16];
    endfunction

    // Expected adder operands and rd for an op, straight from the instruction semantics.
    task automatic push_expect(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                               input int nlanes, input bit with_rd);
        logic [15:0] s[2];
        for (int l = 0; l < 2; l++) begin
            logic [15:0] ea;
            logic [15:0] eb;
            ea = lane_of(a, l);
            eb = lane_of(b, l);
            if (f3[0]) eb[15] = ~eb[15];
            s[l] = bf16_add(ea, eb);
            if (l < nlanes) exp_xfer_q.push_back({ea, eb});
        end
        if (with_rd) exp_rd_q.push_back(f3[1] ? {s[1], s[0]} : {16'h0000, s[0]});
    endtask

    // ---------------- behavioural adder (shares rst with the DUT) ----------------
    initial begin : adder_model
        logic in_fire_prev, out_fire_prev;
        logic [15:0] a_prev, b_prev, sum_hold;
        int cnt;
        adder_BUSY = 0; adder_output_STB = 0; adder_sum = '0;
        hold = 0; in_fire_prev = 0; out_fire_prev = 0; cnt = 0;
        a_prev = '0; b_prev = '0; sum_hold = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 0; adder_output_STB = 0; adder_BUSY = 0;
                in_fire_prev = 0; out_fire_prev = 0;
            end else begin
                if (out_fire_prev) begin
                    adder_output_STB = 0;
                    hold = 0;
                end
                if (in_fire_prev) begin
                    hold = 1;
                    sum_hold = bf16_add(a_prev, b_prev);
                    cnt = $urandom_range(0, 2);
                    xfer_count++;
                end
                if (hold && !adder_output_STB) begin
                    if (cnt == 0) begin
                        adder_output_STB = 1;
                        adder_sum = sum_hold;
                    end else begin
                        cnt--;
                    end
                end
                adder_BUSY = hold || force_busy || (rand_busy && ($urandom_range(0, 3) == 0));
                in_fire_prev = adder_input_STB && !adder_BUSY;
                a_prev = adder_input_a;
                b_prev = adder_input_b;
                out_fire_prev = adder_output_STB && !output_module_BUSY;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic        hold_prev;
        logic [15:0] a_hold, b_hold;
        logic [31:0] e;
        hold_prev = 0; a_hold = '0; b_hold = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                hold_prev = 0;
            end else begin
                if (hold_prev && adder_input_STB) begin
                    chk("ab_stable", {adder_input_a, adder_input_b}, {a_hold, b_hold});
                end
                if (adder_input_STB && !adder_BUSY) begin
                    if (exp_xfer_q.size() == 0) begin
                        chk("unexpected_xfer", {adder_input_a, adder_input_b}, 64'hx);
                    end else begin
                        e = exp_xfer_q.pop_front();
                        chk("adder_operands", {adder_input_a, adder_input_b}, e);
                    end
                end
                hold_prev = adder_input_STB && adder_BUSY;
                a_hold = adder_input_a;
                b_hold = adder_input_b;
                if (pcpi_ready) begin
                    ready_count++;
                    if (exp_rd_q.size() == 0) begin
                        chk("unexpected_ready", pcpi_rd, 64'hx);
                    end else begin
                        e = exp_rd_q.pop_front();
                        $display("op done rd=%h expected=%h", pcpi_rd, e);
                        chk("rd", pcpi_rd, e);
                        chk("wr_with_ready", pcpi_wr, 1);
                    end
                end
            end
        end
    end

    // ---------------- core-side stimulus ----------------
    task automatic wait_ready(output logic [31:0] rd_seen);
        bit got;
        got = 0;
        rd_seen = '0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            if (pcpi_ready) begin
                got = 1;
                rd_seen = pcpi_rd;
            end
        end
        if (!got) chk("ready_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                          output logic [31:0] rd_seen);
        push_expect(a, b, f3, f3[1] ? 2 : 1, 1);
        pcpi_insn  = mk_insn(F7, f3);
        pcpi_rs1   = a;
        pcpi_rs2   = b;
        pcpi_valid = 1;
        wait_ready(rd_seen);
        pcpi_valid = 0;
        @(negedge clk);
    endtask

    function automatic logic [15:0] rand_bf();
        logic [7:0] e;
        e = 8'(120 + $urandom_range(0, 14));
        return {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
    endfunction

    initial begin : stim
        logic [31:0] rd;
        logic [15:0] ra, rb;
        bit ok;
        int xc, rc;

        rst = 1; pcpi_valid = 0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_wr", pcpi_wr, 0);
        chk("rst_ready", pcpi_ready, 0);
        chk("rst_wait", pcpi_wait, 0);
        chk("rst_stb", adder_input_STB, 0);
        chk("rst_ombusy", output_module_BUSY, 1);
        chk("rst_rd", pcpi_rd, 0);
        chk("rst_ab", {adder_input_a, adder_input_b}, 0);
        #2 rst = 0;
        @(negedge clk);

        // Directed scalar add, scalar sub, packed add
        run_op(32'h00003F80, 32'h00004000, 3'd0, rd);
        chk("fadd_rd", rd, 32'h00004040);
        run_op(32'h00003F80, 32'h00003F80, 3'd1, rd);
        chk("fsub_rd", rd, 32'h00000000);
        xc = xfer_count;
        run_op(32'h40003F80, 32'h3F803F80, 3'd2, rd);
        chk("packed_rd", rd, 32'h40404000);
        chk("packed_xfers", xfer_count - xc, 2);

        // Backpressure in ISSUE
        force_busy = 1;
        @(negedge clk);
        push_expect(32'h00004000, 32'h00003F80, 3'd1, 1, 1);
        pcpi_insn = mk_insn(F7, 3'd1); pcpi_rs1 = 32'h00004000; pcpi_rs2 = 32'h00003F80;
        pcpi_valid = 1;
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = adder_input_STB;
        end
        chk("bp_stb_seen", ok, 1);
        chk("bp_wait", pcpi_wait, 1);
        ra = adder_input_a; rb = adder_input_b;
        xc = xfer_count;
        ok = 1;
        repeat (5) begin
            @(negedge clk);
            if (!adder_input_STB || adder_input_a != ra || adder_input_b != rb) ok = 0;
        end
        chk("bp_hold", ok, 1);
        force_busy = 0;
        wait_ready(rd);
        pcpi_valid = 0;
        @(negedge clk);
        chk("bp_rd", rd, 32'h00003F80);
        chk("bp_one_xfer", xfer_count - xc, 1);

        // Non-matching instruction is ignored
        pcpi_insn = mk_insn(7'd0, 3'd0); pcpi_valid = 1;
        ok = 1;
        repeat (20) begin
            @(negedge clk);
            if (pcpi_wait || pcpi_ready || adder_input_STB) ok = 0;
        end
        chk("nonmatch_quiet", ok, 1);
        pcpi_valid = 0;
        @(negedge clk);

        // Abort while stalled in ISSUE: STB drops, nothing transferred
        force_busy = 1;
        @(negedge clk);
        xc = xfer_count;
        pcpi_insn = mk_insn(F7, 3'd0); pcpi_rs1 = 32'h3F803F80; pcpi_rs2 = 32'h3F803F80;
        pcpi_valid = 1;
        repeat (3) @(negedge clk);
        pcpi_valid = 0;
        repeat (2) @(negedge clk);
        chk("abort_issue_idle", {adder_input_STB, pcpi_wait}, 2'b00);
        force_busy = 0;
        repeat (4) @(negedge clk);
        chk("abort_issue_noxfer", xfer_count - xc, 0);

        // Abort in WAIT: result drained, no ready pulse
        rc = ready_count;
        push_expect(32'h00004000, 32'h00004000, 3'd0, 1, 0);
        pcpi_insn = mk_insn(F7, 3'd0); pcpi_rs1 = 32'h00004000; pcpi_rs2 = 32'h00004000;
        pcpi_valid = 1;
        ok = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            ok = !output_module_BUSY;
        end
        chk("abort_wait_reached", ok, 1);
        pcpi_valid = 0;
        repeat (15) @(negedge clk);
        chk("abort_wait_noready", ready_count - rc, 0);
        chk("abort_wait_drained", {hold, adder_output_STB, pcpi_wait}, 3'b000);

        // Asynchronous reset in the middle of a packed op
        push_expect(32'h40404040, 32'h3F803F80, 3'd2, 2, 1);
        pcpi_insn = mk_insn(F7, 3'd2); pcpi_rs1 = 32'h40404040; pcpi_rs2 = 32'h3F803F80;
        pcpi_valid = 1;
        repeat (4) @(negedge clk);
        #2 rst = 1;
        pcpi_valid = 0;
        #1;
        chk("arst_outputs",
            {pcpi_wr, pcpi_ready, pcpi_wait, adder_input_STB, output_module_BUSY,
             pcpi_rd, adder_input_a, adder_input_b},
            {5'b00001, 32'h0, 16'h0, 16'h0});
        exp_xfer_q.delete();
        exp_rd_q.delete();
        repeat (2) @(negedge clk);
        #2 rst = 0;
        @(negedge clk);
        run_op(32'h3F804000, 32'h3F803F80, 3'd3, rd);
        chk("post_rst_rd", rd, 32'h00003F80);

        // Randomised ops with random adder backpressure and latency
        rand_busy = 1;
        for (int i = 0; i < 40; i++) begin
            logic [2:0] f3;
            f3 = 3'($urandom_range(0, 3));
            run_op({rand_bf(), rand_bf()}, {rand_bf(), rand_bf()}, f3, rd);
        end
        rand_busy = 0;

        repeat (5) @(negedge clk);
        chk("xfer_q_empty", exp_xfer_q.size(), 0);
        chk("rd_q_empty", exp_rd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
